mult_share_ctrl: RTL
====================

# mult_share_ctrl

Round-robin arbiter and sequencer that shares one multi-cycle 16x16 signed Booth multiplier among NREQ requesters. Each requester presents operands on a valid/ready handshake. The block grants one request at a time, loads and starts the multiplier, waits for its done strobe, and returns the 32-bit product with the requester ID on a held response channel. A watchdog aborts stuck operations and flushes the multiplier.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width; product is 2W
- TIMEOUT, 31, maximum cycles spent in WAIT before abort (>= 2)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant/accept, asserted only in IDLE
- req_x  in  NREQ*W  operand x, requester i at bits [i*W +: W]
- req_y  in  NREQ*W  operand y, same packing
- rsp_valid  out  1  response valid, held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_id  out  3  index of the requester being answered
- rsp_prod  out  2W  signed product; 0 when rsp_err=1
- rsp_err  out  1  operation aborted by the watchdog
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_x, mul_y  out  W  operands, stable from ISSUE until return to IDLE
- mul_flush  out  1  one-cycle pulse, ORed into the multiplier's reset
- mul_done  in  1  multiplier done strobe (sampled in WAIT only)
- mul_prod  in  2W  multiplier result, valid with mul_done
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Reset: state=IDLE and last_grant=NREQ-1, so requester 0 has priority first. All outputs are 0: req_ready, rsp_*, mul_start, mul_x, mul_y, mul_flush and busy. The watchdog counter is 0.
- IDLE:
  - Winner = first i with req_valid[i], searching from last_grant+1 modulo NREQ.
  - req_ready is combinational: one-hot on the winner, 0 when no request is valid.
  - On the edge, the winner's x/y are latched into mul_x/mul_y, its ID into rsp_id, last_grant is set to the winner, and state moves to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle. The counter clears. Next state is WAIT. A mul_done seen in this cycle is ignored.
- WAIT:
  - If mul_done=1: latch mul_prod into rsp_prod, set rsp_err=0, go to RESP.
  - Otherwise, if counter==TIMEOUT-1: set rsp_prod=0 and rsp_err=1, pulse mul_flush on the next cycle, go to RESP.
  - Otherwise: increment the counter.
  - If mul_done and the timeout coincide, done wins.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_prod and rsp_err held stable.
  - When rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
- The product is passed through unmodified; the arbiter does no arithmetic on it.
- mul_done outside WAIT is ignored. After a flush, a late done from the aborted operation cannot occur.
- Requests never receive req_ready outside IDLE. Requesters must hold valid and operands until they are granted.
- Reset mid-operation in any state returns to the reset values on the next edge. No response is issued for the in-flight request.

## Timing
- Grant in cycle T (IDLE, req_ready high).
- mul_start is high in T+1.
- WAIT begins at T+2.
- If mul_done arrives in cycle D (D >= T+2), rsp_valid is high from D+1.
- If rsp_ready is high in D+1, state is IDLE at D+2 and the next grant can occur in D+2.
- Minimum turnaround is 4 cycles plus the multiplier latency.
- Timeout: with no done, the last WAIT cycle is T+1+TIMEOUT. rsp_err=1 is visible from T+2+TIMEOUT, and mul_flush is high in that same cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 operations.

## Test plan
- Single request, requester 0, x=3, y=-4, multiplier model with 9-cycle latency:
  - mul_start in T+1.
  - rsp_valid at T+11 with rsp_id=0, rsp_prod=0xFFFFFFF4, rsp_err=0.
- All 4 requesters valid from reset with distinct operands and rsp_ready=1:
  - Grant order is 0,1,2,3,0.
  - Each rsp_id matches its own product.
  - req_ready is never asserted outside IDLE.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP:
  - rsp_* stays stable.
  - No new grant occurs while a second requester is valid.
  - The grant follows the cycle after acceptance.
- Watchdog: mul_done tied low.
  - rsp_err=1 and rsp_prod=0 at T+2+TIMEOUT.
  - mul_flush pulses once.
  - The next request completes normally.
- Extremes: x=-32768, y=-32768 gives rsp_prod=0x40000000. x=32767, y=-32768 gives 0xC0008000.
- Reset asserted in WAIT, then mul_done pulsed: all outputs are 0 and busy=0. No response appears, and requester 0 is granted first afterwards.

Source files
------------

// File: rtl/mult_share_if.sv
// mult_share_if: requester and response channels of the shared multiplier controller
interface mult_share_if #(
   parameter int NREQ = 4,
   parameter int W = 16
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic rsp_valid;
   logic rsp_ready;
   logic [2:0] rsp_id;
   logic [2*W-1:0] rsp_prod;
   logic rsp_err;
   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
   );
   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
   );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one multi-cycle multiplier with a watchdog abort
module mult_share_ctrl #(
   parameter int NREQ = 4,
   parameter int W = 16,
   parameter int TIMEOUT = 31
) (
   input  logic clk,
   input  logic reset,
   mult_share_if.slave bus,
   output logic mul_start,
   output logic [W-1:0] mul_x,
   output logic [W-1:0] mul_y,
   output logic mul_flush,
   input  logic mul_done,
   input  logic [2*W-1:0] mul_prod,
   output logic busy
);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state;
   logic [2:0] last_grant;
   logic [2:0] winner;
   logic [NREQ-1:0] win_oh;
   logic [W-1:0] win_x;
   logic [W-1:0] win_y;
   logic [CW-1:0] cnt;
   logic any_req;
   assign any_req = |bus.req_valid;
   assign bus.req_ready = (state == IDLE) ? win_oh : '0;
   // round-robin pick: scan from farthest to nearest after last_grant so the nearest valid one wins
   always_comb begin
      winner = last_grant;
      win_oh = '0;
      win_x = '0;
      win_y = '0;
      for (int k = NREQ; k >= 1; k--) begin
         int idx;
         idx = (int'(last_grant) + k) % NREQ;
         if (bus.req_valid[idx]) begin
            winner = 3'(idx);
            win_oh = '0;
            win_oh[idx] = 1'b1;
            win_x = bus.req_x[idx*W +: W];
            win_y = bus.req_y[idx*W +: W];
         end
      end
   end
   // sequencer: grant, start, wait for done or watchdog, hold response until accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         last_grant <= 3'(NREQ - 1);
         cnt <= '0;
         mul_start <= 1'b0;
         mul_flush <= 1'b0;
         mul_x <= '0;
         mul_y <= '0;
         busy <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id <= '0;
         bus.rsp_prod <= '0;
         bus.rsp_err <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         mul_flush <= 1'b0;
         case (state)
            IDLE: if (any_req) begin
               mul_x <= win_x;
               mul_y <= win_y;
               bus.rsp_id <= winner;
               last_grant <= winner;
               mul_start <= 1'b1;
               busy <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: begin
               cnt <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (mul_done) begin
                  bus.rsp_prod <= mul_prod;
                  bus.rsp_err <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  bus.rsp_prod <= '0;
                  bus.rsp_err <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  mul_flush <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: if (bus.rsp_ready) begin
               bus.rsp_valid <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
